// File: rtl/angle_pkg.sv
// Shared types and helpers for the angle tracker: FSM state encoding and
// the slice-count log2 used to derive step length from the period estimate.
package angle_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MEASURE,
    ST_TRACK,
    ST_STALL
  } state_e;

  function automatic int unsigned res_log2(input int unsigned res);
    int unsigned n;
    n = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((res >> i) > 1) n = i + 1;
    end
    return n;
  endfunction

endpackage

// File: rtl/period_filter.sv
// First-order IIR smoothing of the measured revolution period:
// est <= est + ((P - est) >>> AVG_SHIFT), with a direct load on first lock.
module period_filter #(
  parameter int unsigned PERIOD_W  = 24,
  parameter int unsigned AVG_SHIFT = 2
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                load,
  input  logic                update,
  input  logic [PERIOD_W-1:0] P,
  output logic [PERIOD_W-1:0] est
);

  // One guard bit keeps the signed difference exact; the sum always lands
  // between est and P, so the guard bit of the state stays zero.
  logic signed [PERIOD_W:0] est_q, est_d;
  logic signed [PERIOD_W:0] diff;
  logic signed [PERIOD_W:0] adj;

  always_comb begin
    diff  = $signed({1'b0, P}) - est_q;
    adj   = diff >>> AVG_SHIFT;
    est_d = est_q;
    if (load) begin
      est_d = $signed({1'b0, P});
    end else if (update) begin
      est_d = est_q + adj;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      est_q <= '0;
    end else begin
      est_q <= est_d;
    end
  end

  assign est = est_q[PERIOD_W-1:0];

endmodule

// File: rtl/angle_tracker.sv
// Rotational angle tracker: locks to a once-per-revolution IR edge and
// interpolates the angle in ROTATIONAL_RES slices from the filtered period.
module angle_tracker
  import angle_pkg::*;
#(
  parameter int unsigned ROTATIONAL_RES = 1024,
  parameter int unsigned PERIOD_W       = 24,
  parameter int unsigned AVG_SHIFT      = 2,
  parameter int unsigned MIN_PERIOD     = 1024,
  parameter int unsigned STALL_CYCLES   = 2**23
) (
  input  logic                              clk_in,
  input  logic                              rst_in,
  input  logic                              ir_tripped,
  input  logic                              reverse,
  output logic [$clog2(ROTATIONAL_RES)-1:0] dtheta,
  output logic                              theta_valid,
  output logic                              theta_step,
  output logic                              rev_start,
  output logic                              stalled,
  output logic [PERIOD_W-1:0]               period_est
);

  localparam int unsigned          RES_LOG2 = res_log2(ROTATIONAL_RES);
  localparam logic [PERIOD_W-1:0]  MIN_P    = PERIOD_W'(MIN_PERIOD);
  localparam logic [PERIOD_W-1:0]  STALL_P  = PERIOD_W'(STALL_CYCLES);
  localparam logic [PERIOD_W-1:0]  ONE_P    = PERIOD_W'(1);
  localparam logic [RES_LOG2-1:0]  LAST_FWD = RES_LOG2'(ROTATIONAL_RES - 1);
  localparam logic [RES_LOG2-1:0]  LAST_REV = RES_LOG2'(1);
  localparam logic [RES_LOG2-1:0]  ONE_S    = RES_LOG2'(1);

  state_e                state_q, state_d;
  logic                  ir_prev_q, ir_prev_d;
  logic [PERIOD_W-1:0]   cnt_q, cnt_d;
  logic [PERIOD_W-1:0]   step_cnt_q, step_cnt_d;
  logic [RES_LOG2-1:0]   dtheta_q, dtheta_d;
  logic                  dir_q, dir_d;
  logic                  theta_valid_q, theta_valid_d;
  logic                  theta_step_q, theta_step_d;
  logic                  rev_start_q, rev_start_d;
  logic                  stalled_q, stalled_d;

  logic                  edge_seen;
  logic                  accept;
  logic                  filt_load;
  logic                  filt_update;
  logic                  step_hit;
  logic [PERIOD_W-1:0]   period_p;
  logic [PERIOD_W-1:0]   step_len;
  logic [PERIOD_W-1:0]   est;
  logic [RES_LOG2-1:0]   last_slice;

  always_comb begin
    ir_prev_d = ir_tripped;
    edge_seen = ir_tripped & ~ir_prev_q;
    // Glitch rejection only applies once a period is being timed.
    accept    = edge_seen & ((state_q == ST_IDLE) | (state_q == ST_STALL) |
                             (cnt_q >= MIN_P));
    period_p  = cnt_q + ONE_P;

    if (accept) begin
      cnt_d = '0;
    end else if (cnt_q >= STALL_P) begin
      cnt_d = STALL_P;
    end else begin
      cnt_d = cnt_q + ONE_P;
    end

    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (accept) state_d = ST_MEASURE;
      ST_MEASURE: if (accept) state_d = ST_TRACK;
      ST_TRACK:   if (!accept && (cnt_q >= STALL_P)) state_d = ST_STALL;
      ST_STALL:   if (accept) state_d = ST_MEASURE;
      default:    state_d = ST_IDLE;
    endcase

    filt_load   = accept & (state_q == ST_MEASURE);
    filt_update = accept & (state_q == ST_TRACK);
    dir_d       = accept ? reverse : dir_q;

    step_len = est >> RES_LOG2;
    if (step_len == '0) step_len = ONE_P;
    step_hit   = (step_cnt_q >= (step_len - ONE_P));
    last_slice = dir_q ? LAST_REV : LAST_FWD;

    // An accepted edge overrides any step landing in the same cycle.
    step_cnt_d = step_cnt_q;
    dtheta_d   = dtheta_q;
    if (accept) begin
      step_cnt_d = '0;
      dtheta_d   = '0;
    end else if (state_q == ST_TRACK) begin
      if (step_hit) begin
        step_cnt_d = '0;
        if (dtheta_q != last_slice) begin
          dtheta_d = dir_q ? (dtheta_q - ONE_S) : (dtheta_q + ONE_S);
        end
      end else begin
        step_cnt_d = step_cnt_q + ONE_P;
      end
    end

    theta_step_d  = (dtheta_d != dtheta_q);
    rev_start_d   = accept;
    theta_valid_d = (state_d == ST_TRACK);
    stalled_d     = (state_d == ST_STALL);
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q       <= ST_IDLE;
      ir_prev_q     <= 1'b1;
      cnt_q         <= '0;
      step_cnt_q    <= '0;
      dtheta_q      <= '0;
      dir_q         <= 1'b0;
      theta_valid_q <= 1'b0;
      theta_step_q  <= 1'b0;
      rev_start_q   <= 1'b0;
      stalled_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      ir_prev_q     <= ir_prev_d;
      cnt_q         <= cnt_d;
      step_cnt_q    <= step_cnt_d;
      dtheta_q      <= dtheta_d;
      dir_q         <= dir_d;
      theta_valid_q <= theta_valid_d;
      theta_step_q  <= theta_step_d;
      rev_start_q   <= rev_start_d;
      stalled_q     <= stalled_d;
    end
  end

  period_filter #(
    .PERIOD_W  (PERIOD_W),
    .AVG_SHIFT (AVG_SHIFT)
  ) u_filter (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .load   (filt_load),
    .update (filt_update),
    .P      (period_p),
    .est    (est)
  );

  assign dtheta      = dtheta_q;
  assign theta_valid = theta_valid_q;
  assign theta_step  = theta_step_q;
  assign rev_start   = rev_start_q;
  assign stalled     = stalled_q;
  assign period_est  = est;

endmodule

// File: tb/tb_angle_tracker.sv
// Directed bench for angle_tracker with 16 slices, unsmoothed period,
// MIN_PERIOD 8 and STALL_CYCLES 1000; outputs sampled on the falling edge.
module tb_angle_tracker;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        ir_tripped;
  logic        reverse;
  logic [3:0]  dtheta;
  logic        theta_valid;
  logic        theta_step;
  logic        rev_start;
  logic        stalled;
  logic [23:0] period_est;

  int checks = 0;
  int passes = 0;

  logic [3:0] cap_dth   [1:400];
  logic       cap_step  [1:400];
  logic       cap_rs    [1:400];

  always #5 clk_in = ~clk_in;

  angle_tracker #(
    .ROTATIONAL_RES (16),
    .PERIOD_W       (24),
    .AVG_SHIFT      (0),
    .MIN_PERIOD     (8),
    .STALL_CYCLES   (1000)
  ) dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .ir_tripped  (ir_tripped),
    .reverse     (reverse),
    .dtheta      (dtheta),
    .theta_valid (theta_valid),
    .theta_step  (theta_step),
    .rev_start   (rev_start),
    .stalled     (stalled),
    .period_est  (period_est)
  );

  task automatic fire_edge();
    @(negedge clk_in) ir_tripped = 1'b1;
    @(negedge clk_in) ir_tripped = 1'b0;
  endtask

  // Entered one cycle after an accepted edge (t=1); records outputs for t=1..s
  // and raises ir_tripped so the next edge lands exactly s clocks later.
  task automatic run_rev(input int s, input int glitch_t);
    for (int t = 1; t <= s; t++) begin
      cap_dth[t]  = dtheta;
      cap_step[t] = theta_step;
      cap_rs[t]   = rev_start;
      if (glitch_t > 0 && t == glitch_t) ir_tripped = 1'b1;
      else if (glitch_t > 0 && t == glitch_t + 1) ir_tripped = 1'b0;
      if (t == s) ir_tripped = 1'b1;
      @(negedge clk_in);
    end
    ir_tripped = 1'b0;
  endtask

  function automatic int exp_slice(input int t, input int len, input bit rev);
    int n;
    if (len == 0) return 0;
    n = (t - 1) / len;
    if (n > 15) n = 15;
    if (rev && n != 0) return 16 - n;
    return n;
  endfunction

  function automatic int seq_errors(input int s, input int len, input bit rev);
    int e;
    logic [3:0] ex;
    e = 0;
    for (int t = 1; t <= s; t++) begin
      ex = 4'(exp_slice(t, len, rev));
      if (cap_dth[t] !== ex) e++;
    end
    return e;
  endfunction

  function automatic int count_steps(input int s);
    int c;
    c = 0;
    for (int t = 1; t <= s; t++) if (cap_step[t] === 1'b1) c++;
    return c;
  endfunction

  function automatic int count_rs(input int s);
    int c;
    c = 0;
    for (int t = 1; t <= s; t++) if (cap_rs[t] === 1'b1) c++;
    return c;
  endfunction

  task automatic test_reset();
    int rs;
    rst_in = 1'b0; ir_tripped = 1'b1; reverse = 1'b0;
    repeat (3) @(negedge clk_in);
    checks++;
    if ({dtheta, theta_valid, theta_step, rev_start, stalled, period_est} !== 32'd0)
      $display("FAIL reset_outputs: got %h expected 0",
               {dtheta, theta_valid, theta_step, rev_start, stalled, period_est});
    else passes++;
    rst_in = 1'b1;
    rs = 0;
    repeat (6) begin
      @(negedge clk_in);
      if (rev_start === 1'b1) rs++;
    end
    checks++;
    if (rs !== 0) $display("FAIL release_high_no_edge: rev_start pulses %0d expected 0", rs);
    else passes++;
    ir_tripped = 1'b0;
    @(negedge clk_in);
    checks++;
    if (theta_valid !== 1'b0) $display("FAIL idle_not_valid: got %b expected 0", theta_valid);
    else passes++;
  endtask

  task automatic test_lock();
    int n;
    fire_edge();
    checks++;
    if (rev_start !== 1'b1) $display("FAIL first_edge_rev_start: got %b expected 1", rev_start);
    else passes++;
    checks++;
    if (theta_valid !== 1'b0) $display("FAIL measure_not_valid: got %b expected 0", theta_valid);
    else passes++;
    run_rev(160, 0);
    n = seq_errors(160, 0, 1'b0);
    checks++;
    if (n !== 0) $display("FAIL measure_dtheta_held: %0d bad slices expected 0", n);
    else passes++;
    checks++;
    if (count_steps(160) !== 0) $display("FAIL measure_no_steps: got %0d expected 0", count_steps(160));
    else passes++;
    checks++;
    if (theta_valid !== 1'b1) $display("FAIL lock_valid: got %b expected 1", theta_valid);
    else passes++;
    checks++;
    if (period_est !== 24'd160) $display("FAIL lock_period_est: got %0d expected 160", period_est);
    else passes++;
    run_rev(160, 0);
    n = seq_errors(160, 10, 1'b0);
    checks++;
    if (n !== 0) $display("FAIL track_seq_160: %0d bad slices expected 0", n);
    else passes++;
    checks++;
    if (count_steps(160) !== 15) $display("FAIL first_track_steps: got %0d expected 15", count_steps(160));
    else passes++;
    run_rev(160, 0);
    checks++;
    if (count_steps(160) !== 16) $display("FAIL steps_per_rev: got %0d expected 16", count_steps(160));
    else passes++;
    checks++;
    if (period_est !== 24'd160) $display("FAIL steady_period_est: got %0d expected 160", period_est);
    else passes++;
  endtask

  task automatic test_speed_up();
    int n;
    run_rev(80, 0);
    checks++;
    if (cap_dth[80] !== 4'd7) $display("FAIL speedup_last_slice: got %0d expected 7", cap_dth[80]);
    else passes++;
    n = seq_errors(80, 10, 1'b0);
    checks++;
    if (n !== 0) $display("FAIL speedup_seq: %0d bad slices expected 0", n);
    else passes++;
    checks++;
    if (period_est !== 24'd80) $display("FAIL speedup_period_est: got %0d expected 80", period_est);
    else passes++;
    run_rev(80, 0);
    n = seq_errors(80, 5, 1'b0);
    checks++;
    if (n !== 0) $display("FAIL fast_seq: %0d bad slices expected 0", n);
    else passes++;
    checks++;
    if (count_steps(80) !== 16) $display("FAIL fast_steps: got %0d expected 16", count_steps(80));
    else passes++;
  endtask

  task automatic test_slow_down();
    int n;
    run_rev(160, 0);
    n = seq_errors(160, 5, 1'b0);
    checks++;
    if (n !== 0) $display("FAIL early_hold_seq: %0d bad slices expected 0", n);
    else passes++;
    checks++;
    if (period_est !== 24'd160) $display("FAIL relock_160_est: got %0d expected 160", period_est);
    else passes++;
    run_rev(320, 0);
    n = seq_errors(320, 10, 1'b0);
    checks++;
    if (n !== 0) $display("FAIL slow_seq: %0d bad slices expected 0", n);
    else passes++;
    checks++;
    if (cap_dth[151] !== 4'd15 || cap_dth[320] !== 4'd15)
      $display("FAIL hold_until_edge: got %0d/%0d expected 15/15", cap_dth[151], cap_dth[320]);
    else passes++;
    checks++;
    if (rev_start !== 1'b1 || dtheta !== 4'd0)
      $display("FAIL slow_edge_restart: rev_start %b dtheta %0d expected 1 and 0", rev_start, dtheta);
    else passes++;
    checks++;
    if (period_est !== 24'd320) $display("FAIL slow_period_est: got %0d expected 320", period_est);
    else passes++;
    run_rev(160, 0);
    n = seq_errors(160, 20, 1'b0);
    checks++;
    if (n !== 0) $display("FAIL short_after_long_seq: %0d bad slices expected 0", n);
    else passes++;
  endtask

  task automatic test_glitch();
    int n;
    run_rev(160, 3);
    checks++;
    if (count_rs(160) !== 1) $display("FAIL glitch_rev_start: got %0d pulses expected 1", count_rs(160));
    else passes++;
    n = seq_errors(160, 10, 1'b0);
    checks++;
    if (n !== 0) $display("FAIL glitch_dtheta: %0d bad slices expected 0", n);
    else passes++;
    checks++;
    if (period_est !== 24'd160) $display("FAIL glitch_period_est: got %0d expected 160", period_est);
    else passes++;
  endtask

  task automatic test_stall();
    logic s995, v995;
    s995 = 1'bx; v995 = 1'bx;
    for (int t = 1; t < 1005; t++) begin
      if (t == 995) begin
        s995 = stalled;
        v995 = theta_valid;
      end
      @(negedge clk_in);
    end
    checks++;
    if (s995 !== 1'b0 || v995 !== 1'b1)
      $display("FAIL pre_stall: stalled %b valid %b expected 0 1", s995, v995);
    else passes++;
    checks++;
    if (stalled !== 1'b1 || theta_valid !== 1'b0)
      $display("FAIL stall_flags: stalled %b valid %b expected 1 0", stalled, theta_valid);
    else passes++;
    checks++;
    if (period_est !== 24'd160 || dtheta !== 4'd15)
      $display("FAIL stall_hold: est %0d dtheta %0d expected 160 15", period_est, dtheta);
    else passes++;
    fire_edge();
    checks++;
    if (rev_start !== 1'b1 || stalled !== 1'b0 || theta_valid !== 1'b0)
      $display("FAIL stall_to_measure: rs %b stalled %b valid %b expected 1 0 0",
               rev_start, stalled, theta_valid);
    else passes++;
    checks++;
    if (period_est !== 24'd160) $display("FAIL stall_exit_est: got %0d expected 160", period_est);
    else passes++;
  endtask

  task automatic test_reverse();
    int n;
    rst_in = 1'b0;
    @(negedge clk_in);
    rst_in = 1'b1; reverse = 1'b1;
    fire_edge();
    run_rev(160, 0);
    checks++;
    if (theta_valid !== 1'b1) $display("FAIL reverse_lock: got %b expected 1", theta_valid);
    else passes++;
    run_rev(160, 0);
    n = seq_errors(160, 10, 1'b1);
    checks++;
    if (n !== 0) $display("FAIL reverse_seq: %0d bad slices expected 0", n);
    else passes++;
    checks++;
    if (cap_dth[11] !== 4'd15 || cap_dth[160] !== 4'd1)
      $display("FAIL reverse_wrap_hold: got %0d/%0d expected 15/1", cap_dth[11], cap_dth[160]);
    else passes++;
    checks++;
    if (count_steps(160) !== 15) $display("FAIL reverse_steps: got %0d expected 15", count_steps(160));
    else passes++;
    reverse = 1'b0;
    repeat (49) @(negedge clk_in);
    checks++;
    if (dtheta !== 4'd12) $display("FAIL reverse_sampled_on_edge: got %0d expected 12", dtheta);
    else passes++;
    rst_in = 1'b0;
    @(negedge clk_in);
    checks++;
    if ({dtheta, theta_valid, theta_step, rev_start, stalled, period_est} !== 32'd0)
      $display("FAIL midrev_reset: got %h expected 0",
               {dtheta, theta_valid, theta_step, rev_start, stalled, period_est});
    else passes++;
    rst_in = 1'b1;
    fire_edge();
    checks++;
    if (theta_valid !== 1'b0) $display("FAIL relock_one_edge: got %b expected 0", theta_valid);
    else passes++;
    run_rev(160, 0);
    checks++;
    if (theta_valid !== 1'b1 || period_est !== 24'd160)
      $display("FAIL relock_two_edges: valid %b est %0d expected 1 160", theta_valid, period_est);
    else passes++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_lock();
    test_speed_up();
    test_slow_down();
    test_glitch();
    test_stall();
    test_reverse();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/angle_tracker.md
ANGLE_TRACKER -- requirements
Module: angle_tracker

Interface
REQ-001 Parameter ROTATIONAL_RES, default 1024: angular slices per revolution; SHALL be a power of two, at least 4.
REQ-002 Parameter PERIOD_W, default 24: width of the period counter and estimate in bits.
REQ-003 Parameter AVG_SHIFT, default 2: smoothing shift of the period filter; 0 means each new period is used directly.
REQ-004 Parameter MIN_PERIOD, default 1024: edges arriving fewer clocks than this after the last accepted edge are glitches.
REQ-005 Parameter STALL_CYCLES, default 2**23: clocks without an accepted edge before a stall is declared; SHALL be less than 2**PERIOD_W.
REQ-006 clk_in  input  1  single clock for the block; all logic on its rising edge.
REQ-007 rst_in  input  1  synchronous, active-low reset.
REQ-008 ir_tripped  input  1  debounced IR level; a 0->1 transition marks angle zero.
REQ-009 reverse  input  1  1 = dtheta counts downward; sampled only on accepted edges.
REQ-010 dtheta  output  $clog2(ROTATIONAL_RES)  current angular slice.
REQ-011 theta_valid  output  1  high only in TRACK.
REQ-012 theta_step  output  1  one-cycle pulse on every dtheta change.
REQ-013 rev_start  output  1  one-cycle pulse on every accepted edge.
REQ-014 stalled  output  1  high in STALL.
REQ-015 period_est  output  PERIOD_W  filtered revolution period, in clocks.

Function
REQ-016 States SHALL be IDLE, MEASURE, TRACK and STALL.
REQ-017 Transitions:
- IDLE -> MEASURE on the first edge.
- MEASURE -> TRACK on the next accepted edge.
- TRACK -> STALL when the period counter reaches STALL_CYCLES.
- STALL -> MEASURE on an edge.
REQ-018 An edge is ir_tripped=1 in cycle k with ir_tripped=0 in cycle k-1; it SHALL be accepted when the period counter is at least MIN_PERIOD, and always in IDLE and STALL.
REQ-019 The period counter SHALL clear on an accepted edge, otherwise increment, saturating at STALL_CYCLES.
REQ-020 On an accepted edge, the captured period P SHALL be the counter value plus 1.
REQ-021 Filter update, signed PERIOD_W+1 arithmetic, applied on each accepted edge in TRACK or at MEASURE->TRACK:
- est = est + ((P - est) >>> AVG_SHIFT);
- at MEASURE->TRACK, est SHALL be loaded with P directly.
REQ-022 Step length SHALL be period_est >> log2(ROTATIONAL_RES), clamped to a minimum of 1.
REQ-023 In TRACK, a step counter SHALL advance dtheta by one slice every step-length clocks:
- forward: +1; reverse: -1 mod ROTATIONAL_RES;
- dtheta SHALL hold at the final slice (ROTATIONAL_RES-1 forward, 1 reverse) until the next edge.
REQ-024 On an accepted edge, registered on cycle k+1, the block SHALL:
- set dtheta to 0;
- clear the step counter;
- pulse rev_start;
- pulse theta_step if dtheta changed;
- make the new period_est visible.
REQ-025 If an accepted edge and a step fall in the same cycle, the edge SHALL win and the step is discarded.
REQ-026 Rejected edges SHALL have no effect on any state or output.
REQ-027 In IDLE, MEASURE and STALL, dtheta SHALL be held and theta_step SHALL stay 0.
REQ-028 In STALL, period_est SHALL be held.

Reset
REQ-029 While rst_in=0 at a clock edge, the block SHALL go to IDLE and:
- dtheta=0, theta_valid=0, theta_step=0, rev_start=0, stalled=0, period_est=0;
- clear both counters;
- set the edge-detect history to 1, so a high ir_tripped at reset release is not an edge.
REQ-030 Reset mid-revolution SHALL discard all tracking; lock needs two further edges.

Structure
REQ-031 Package angle_pkg SHALL hold the state enum typedef and a function giving log2 of ROTATIONAL_RES.
REQ-032 Sub-module period_filter SHALL implement REQ-021:
- inputs: clk_in, rst_in, load, update, P;
- output: est.
REQ-033 The remaining logic SHALL stay in angle_tracker.

Verification
Parameters for all scenarios: ROTATIONAL_RES=16, AVG_SHIFT=0, MIN_PERIOD=8, STALL_CYCLES=1000.
REQ-034 Bench SHALL cover the scenarios below.
- Edges every 160 clocks -> TRACK after the 2nd edge; period_est=160; dtheta steps 0..15 every 10 clocks; 16 theta_step pulses per revolution.
- Edge spacing changes from 160 to 80 -> dtheta holds at 15 never; next revolution steps every 5 clocks.
- Spacing 320 after lock at 160 -> dtheta saturates at 15 after 150 clocks and holds until the edge; rev_start then dtheta=0.
- Glitch 3 clocks after an accepted edge -> no rev_start, dtheta unchanged.
- Edges stop -> stalled=1 and theta_valid=0 after 1000 clocks; next edge -> MEASURE.
- reverse=1 -> sequence 0,15,14..1 holding at 1; rst_in=0 mid-revolution -> all outputs 0 on the next clock.
